// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler that time-shares one external WIDTH-bit adder among NUM_REQ requesters,
// registering the winner's operands and returning the captured sum with the winner's ID.
module adder_rr_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 18,
  parameter int unsigned ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  input  logic [NUM_REQ-1:0]         req_cin,
  output logic [WIDTH-1:0]           add_a,
  output logic [WIDTH-1:0]           add_b,
  output logic                       add_cin,
  input  logic [WIDTH:0]             add_sum,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [WIDTH:0]             rsp_sum
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [WIDTH-1:0]  add_a_q, add_a_d;
  logic [WIDTH-1:0]  add_b_q, add_b_d;
  logic              add_cin_q, add_cin_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH:0]    rsp_sum_q, rsp_sum_d;

  logic              found;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   winner_nxt;
  int unsigned       idx;
  logic [WIDTH-1:0]  win_a, win_b;
  logic              win_cin;

  // Rotating priority search starting at ptr_q
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // Winner operand select and pointer advance with wrap
  always_comb begin
    win_a   = '0;
    win_b   = '0;
    win_cin = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        win_a   = req_a[i*WIDTH +: WIDTH];
        win_b   = req_b[i*WIDTH +: WIDTH];
        win_cin = req_cin[i];
      end
    end
    winner_nxt = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    req_ready   = '0;
    unique case (state_q)
      IDLE: begin
        if (found && !rst) begin
          req_ready = NUM_REQ'(1) << winner;
          add_a_d   = win_a;
          add_b_d   = win_b;
          add_cin_d = win_cin;
          gid_d     = winner;
          ptr_d     = winner_nxt;
          state_d   = CALC;
        end
      end
      CALC: begin
        rsp_sum_d   = add_sum;
        rsp_id_d    = gid_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gid_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;

endmodule
